// File: rtl/cfg_writer_pkg.sv
// Shared definitions for the SPI configuration-memory writer: FSM encoding and default geometry.
package cfg_writer_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StGetAddr = 2'd1,
        StGetData = 2'd2
    } cfg_state_e;

    localparam int unsigned CFG_MEM_DEPTH = 149;
    localparam int unsigned CFG_ADDR_W    = 8;
    localparam int unsigned CFG_DATA_W    = 8;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin, with single-cycle rise/fall pulses
// derived from the synchronised level.
module spi_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] stages_q;
    logic                   prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stages_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q   <= RESET_VAL;
        end else begin
            stages_q <= {stages_q[SYNC_STAGES-2:0], din};
            prev_q   <= stages_q[SYNC_STAGES-1];
        end
    end

    assign level = stages_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/cfg_spi_writer.sv
// SPI mode-0 slave turning an address byte plus data bytes into byte-wide memory write strobes.
// Optional feature: CFG_SPI_WRITER_CHECKSUM_EN enables a per-frame XOR checksum of written bytes.
module cfg_spi_writer
    import cfg_writer_pkg::*;
#(
    parameter int unsigned MEM_DEPTH   = CFG_MEM_DEPTH,
    parameter int unsigned ADDR_W      = CFG_ADDR_W,
    parameter int unsigned DATA_W      = CFG_DATA_W,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              spi_sclk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_we,
    output logic              busy,
    output logic              overflow,
    output logic [ADDR_W-1:0] byte_count,
    output logic [DATA_W-1:0] checksum
);

    localparam int unsigned CNT_W = $clog2(DATA_W);
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(MEM_DEPTH);

    logic sclk_level, sclk_rise, sclk_fall;
    logic cs_level, cs_rise, cs_fall;
    logic unused_sclk;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk   (clk),
        .reset (reset),
        .din   (spi_sclk),
        .level (sclk_level),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    // cs_n idles high, so reset its synchroniser high to avoid a phantom frame start.
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk   (clk),
        .reset (reset),
        .din   (spi_cs_n),
        .level (cs_level),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    assign unused_sclk = ^{sclk_level, sclk_fall};

    logic [SYNC_STAGES-1:0] mosi_q;
    logic                   mosi_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) mosi_q <= '0;
        else       mosi_q <= {mosi_q[SYNC_STAGES-2:0], spi_mosi};
    end

    assign mosi_sync = mosi_q[SYNC_STAGES-1];

    cfg_state_e        state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d, new_byte;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic              mem_we_q, mem_we_d;
    logic              overflow_q, overflow_d;
    logic [ADDR_W-1:0] byte_count_q, byte_count_d;
    logic              frame_start;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            ptr_q        <= '0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            mem_we_q     <= 1'b0;
            overflow_q   <= 1'b0;
            byte_count_q <= '0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            ptr_q        <= ptr_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            mem_we_q     <= mem_we_d;
            overflow_q   <= overflow_d;
            byte_count_q <= byte_count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        ptr_d        = ptr_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        mem_we_d     = 1'b0;
        overflow_d   = overflow_q;
        byte_count_d = byte_count_q;
        frame_start  = 1'b0;
        new_byte     = {shift_q[DATA_W-2:0], mosi_sync};

        unique case (state_q)
            StIdle: begin
                if (cs_fall) begin
                    frame_start  = 1'b1;
                    state_d      = StGetAddr;
                    bit_cnt_d    = '0;
                    shift_d      = '0;
                    byte_count_d = '0;
                    overflow_d   = 1'b0;
                end
            end
            StGetAddr, StGetData: begin
                if (sclk_rise) begin
                    shift_d   = new_byte;
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                        bit_cnt_d = '0;
                        if (state_q == StGetAddr) begin
                            ptr_d   = new_byte[ADDR_W-1:0];
                            state_d = StGetData;
                        end else begin
                            if ({1'b0, ptr_q} < DEPTH_LIM) begin
                                mem_we_d   = 1'b1;
                                mem_addr_d = ptr_q;
                                mem_data_d = new_byte;
                                if (byte_count_q != '1) byte_count_d = byte_count_q + ADDR_W'(1);
                            end else begin
                                overflow_d = 1'b1;
                            end
                            if (ptr_q != '1) ptr_d = ptr_q + ADDR_W'(1);
                        end
                    end
                end
                // A byte completing on the same cycle as cs_n rise is still written above.
                if (cs_rise) begin
                    state_d   = StIdle;
                    bit_cnt_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign mem_addr   = mem_addr_q;
    assign mem_data   = mem_data_q;
    assign mem_we     = mem_we_q;
    assign busy       = ~cs_level;
    assign overflow   = overflow_q;
    assign byte_count = byte_count_q;

`ifdef CFG_SPI_WRITER_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)            checksum_q <= '0;
        else if (frame_start) checksum_q <= '0;
        else if (mem_we_d)    checksum_q <= checksum_q ^ mem_data_d;
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

endmodule
